matrix_transpose_stream: RTL and testbench

MATRIX_TRANSPOSE_STREAM -- requirements
Module: matrix_transpose_stream

---
 rtl/matrix_transpose_stream.sv | 213 +++++++++++++++++++++
 tb/tb_matrix_transpose_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_transpose_stream.sv
// matrix_transpose_stream
// Buffers one M_ROWS x N_COLS matrix arriving row-major on a valid/ready
// stream, then replays it either transposed (row-major of A^T) or unchanged.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mode              0 = transpose, 1 = passthrough (taken on first beat)
//   flush             synchronous abort of the matrix in progress
//   in_valid/in_ready/in_data/in_last    input element stream
//   out_valid/out_ready/out_data/out_last output element stream
//   busy              matrix partially filled or draining
//   done              one-cycle pulse after the last output handshake
//   err               sticky framing error (in_last misplaced)
module matrix_transpose_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned M_ROWS     = 2,
    parameter int unsigned N_COLS     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned TOTAL = M_ROWS * N_COLS;
    localparam int unsigned RW    = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;
    localparam int unsigned CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int unsigned TW    = (TOTAL > 1)  ? $clog2(TOTAL)  : 1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Write position in A (row, column), advancing column first
    logic [RW-1:0] in_r_q, in_r_d;
    logic [CW-1:0] in_c_q, in_c_d;
    // Read position in A^T: out_r walks columns of A, out_c walks rows of A
    logic [CW-1:0] out_r_q, out_r_d;
    logic [RW-1:0] out_c_q, out_c_d;
    logic [TW-1:0] out_cnt_q, out_cnt_d;
    logic          mode_q, mode_d;

    logic                  in_ready_d, out_valid_d, out_last_d;
    logic                  busy_d, done_d, err_d;
    logic [DATA_WIDTH-1:0] out_data_d;

    logic [DATA_WIDTH-1:0] mem [TOTAL];

    logic          in_hs, out_hs, in_final, out_final, wr_en;
    logic [TW-1:0] wr_addr, rd_addr;

    assign in_hs     = in_ready & in_valid;
    assign out_hs    = out_valid & out_ready;
    assign in_final  = (in_r_q == RW'(M_ROWS - 1)) && (in_c_q == CW'(N_COLS - 1));
    assign out_final = (out_cnt_q == TW'(TOTAL - 1));
    assign wr_addr   = TW'(32'(in_r_q) * N_COLS + 32'(in_c_q));
    assign wr_en     = in_hs & ~flush;

    // Element buffer; a flushed beat is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TOTAL); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            in_r_q    <= '0;
            in_c_q    <= '0;
            out_r_q   <= '0;
            out_c_q   <= '0;
            out_cnt_q <= '0;
            mode_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_r_q    <= in_r_d;
            in_c_q    <= in_c_d;
            out_r_q   <= out_r_d;
            out_c_q   <= out_c_d;
            out_cnt_q <= out_cnt_d;
            mode_q    <= mode_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        state_d     = state_q;
        in_r_d      = in_r_q;
        in_c_d      = in_c_q;
        out_r_d     = out_r_q;
        out_c_d     = out_c_q;
        out_cnt_d   = out_cnt_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = err;
        rd_addr     = '0;

        if (flush) begin
            // Abort wins over any handshake on the same edge
            state_d     = FILL;
            in_r_d      = '0;
            in_c_d      = '0;
            out_r_d     = '0;
            out_c_d     = '0;
            out_cnt_d   = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    in_ready_d = 1'b1;
                    if (in_hs) begin
                        busy_d = 1'b1;
                        if (in_r_q == '0 && in_c_q == '0) begin
                            mode_d = mode;
                        end
                        if (in_last != in_final) begin
                            err_d = 1'b1;
                        end
                        if (in_final) begin
                            state_d     = DRAIN;
                            in_r_d      = '0;
                            in_c_d      = '0;
                            out_r_d     = '0;
                            out_c_d     = '0;
                            out_cnt_d   = '0;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                            out_last_d  = (TOTAL == 1);
                            // Element 0 leads in both modes; for a 1x1 matrix
                            // it is the beat being written right now
                            out_data_d  = (TOTAL == 1) ? in_data : mem[0];
                        end else if (in_c_q == CW'(N_COLS - 1)) begin
                            in_c_d = '0;
                            in_r_d = in_r_q + 1'b1;
                        end else begin
                            in_c_d = in_c_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (out_final) begin
                            state_d     = FILL;
                            out_r_d     = '0;
                            out_c_d     = '0;
                            out_cnt_d   = '0;
                            in_ready_d  = 1'b1;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            out_cnt_d = out_cnt_q + 1'b1;
                            if (out_c_q == RW'(M_ROWS - 1)) begin
                                out_c_d = '0;
                                out_r_d = out_r_q + 1'b1;
                            end else begin
                                out_c_d = out_c_q + 1'b1;
                            end
                            rd_addr    = mode_q ? out_cnt_d
                                                : TW'(32'(out_c_d) * N_COLS + 32'(out_r_d));
                            out_data_d = mem[rd_addr];
                            out_last_d = (out_cnt_d == TW'(TOTAL - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Self-checking bench for matrix_transpose_stream (default 2x3, 8-bit).
module tb_matrix_transpose_stream;

    localparam int M = 2;
    localparam int N = 3;
    localparam int T = M * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mode = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;

    matrix_transpose_stream #(.DATA_WIDTH(8), .M_ROWS(M), .N_COLS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic err_exp = 1'b0;

    typedef struct {
        logic [5:0][7:0] a;
        bit              md;
        int              last_at;
        int              rdy;      // 0 always ready, 1 toggling 1010.., 2 random
        bit              tog;      // flip mode after the first beat
        logic [5:0][7:0] exp;
        bit              exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0][7:0] p6(input logic [7:0] e0, e1, e2, e3, e4, e5);
        return {e5, e4, e3, e2, e1, e0};
    endfunction

    // k-th output element: A^T is N x M, so k -> A^T[k/M][k%M] = A[k%M][k/M]
    function automatic logic [7:0] model(input logic [5:0][7:0] a, input bit md, input int k);
        if (md) return a[k];
        return a[(k % M) * N + k / M];
    endfunction

    // Drive beats; returns on the falling edge after the last driven beat
    task automatic feed(input logic [5:0][7:0] a, input bit md, input int last_at,
                        input bit tog, input int beats);
        for (int i = 0; i < beats; i++) begin
            @(negedge clk);
            chk("in_ready_fill", in_ready, 1);
            chk("busy_fill", busy, (i > 0) ? 1 : 0);
            in_valid = 1'b1;
            in_data  = a[i];
            in_last  = (i == last_at);
            mode     = (tog && i > 0) ? ~md : md;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Collect one matrix under a back-pressure pattern and check the wrap-up
    task automatic drain(input logic [5:0][7:0] exp, input int rdy, input bit e_err);
        int         k = 0;
        int         cyc = 0;
        logic       hold = 1'b0;
        logic [7:0] pd = '0;
        logic       pl = 1'b0;
        logic       r;
        chk("out_valid_latency", out_valid, 1);
        chk("in_ready_drain", in_ready, 0);
        chk("busy_drain", busy, 1);
        while (k < T && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            if (hold) begin
                chk("hold_data", out_data, pd);
                chk("hold_last", out_last, pl);
            end
            r = (rdy == 0) ? 1'b1 : (rdy == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            out_ready = r;
            if (out_valid && r) begin
                chk("out_data", out_data, exp[k]);
                chk("out_last", out_last, (k == T - 1) ? 1 : 0);
                k++;
                hold = 1'b0;
            end else begin
                hold = out_valid;
                pd   = out_data;
                pl   = out_last;
            end
            cyc++;
        end
        if (k < T) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d elements expected %0d", k, T);
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("out_valid_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
        chk("err", err, e_err);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [5:0][7:0] a;
        logic [5:0][7:0] e;
        bit              md;

        vecs[0] = '{p6(1, 2, 3, 4, 5, 6), 1'b0, 5, 0, 1'b0, p6(1, 4, 2, 5, 3, 6), 1'b0};
        vecs[1] = '{p6(1, 2, 3, 4, 5, 6), 1'b1, 5, 0, 1'b1, p6(1, 2, 3, 4, 5, 6), 1'b0};
        vecs[2] = '{p6(8'hFF, 8'h80, 1, 2, 3, 4), 1'b0, 5, 1, 1'b0,
                    p6(8'hFF, 8'h02, 8'h80, 8'h03, 8'h01, 8'h04), 1'b0};
        vecs[3] = '{p6(1, 2, 3, 4, 5, 6), 1'b0, 2, 0, 1'b0, p6(1, 4, 2, 5, 3, 6), 1'b1};
        vecs[4] = '{p6(7, 8, 9, 10, 11, 12), 1'b0, 5, 2, 1'b0, p6(7, 10, 8, 11, 9, 12), 1'b1};

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("in_ready_before_edge", in_ready, 0);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            feed(vecs[v].a, vecs[v].md, vecs[v].last_at, vecs[v].tog, T);
            drain(vecs[v].exp, vecs[v].rdy, vecs[v].exp_err);
        end
        err_exp = 1'b1;

        // Flush after three beats, with a discarded beat on the flush edge
        feed(p6(20, 21, 22, 23, 24, 25), 1'b0, 5, 1'b0, 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_fill_busy", busy, 0);
        chk("flush_fill_in_ready", in_ready, 1);
        chk("flush_fill_out_valid", out_valid, 0);
        feed(p6(10, 11, 12, 13, 14, 15), 1'b0, 5, 1'b0, T);
        drain(p6(10, 13, 11, 14, 12, 15), 0, err_exp);

        // Flush while draining, colliding with an output handshake
        feed(p6(1, 2, 3, 4, 5, 6), 1'b0, 5, 1'b0, T);
        chk("flush_drain_valid_before", out_valid, 1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("flush_drain_out_valid", out_valid, 0);
        chk("flush_drain_done", done, 0);
        chk("flush_drain_in_ready", in_ready, 1);
        chk("flush_drain_busy", busy, 0);
        @(negedge clk);
        chk("flush_drain_no_done", done, 0);

        // Randomised matrices against the reference model
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < T; i++) a[i] = 8'($urandom);
            md = 1'($urandom_range(0, 1));
            for (int k = 0; k < T; k++) e[k] = model(a, md, k);
            feed(a, md, 5, 1'($urandom_range(0, 1)), T);
            drain(e, 2, err_exp);
        end

        // Reset in the middle of draining
        feed(p6(31, 32, 33, 34, 35, 36), 1'b0, 5, 1'b0, T);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        err_exp = 1'b0;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        feed(p6(8'h81, 2, 3, 4, 5, 8'h7F), 1'b0, 5, 1'b0, T);
        drain(p6(8'h81, 4, 2, 5, 3, 8'h7F), 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
